bsg_counter_credit_down_max_val_p64: RTL

// - Sender-side credit counter; pairs with the receiver's clear/up counter that tallies freed slots.
// - Holds credits available to the sender: decrements when a packet is sent, increments on each credit return.
// - Flags underflow/overflow (sticky).
// - Provides a drain handshake: acknowledges once every outstanding credit has come back.

---
 rtl/bsg_counter_credit_down_max_val_p64.sv | 115 +++++++++++
 1 files changed

// File: rtl/bsg_counter_credit_down_max_val_p64.sv
// Sender-side credit counter: saturating count with sticky under/overflow error
// and a drain handshake that acknowledges once the full credit pool is back.
module bsg_counter_credit_down_max_val_p64 #(
  parameter int max_val_p  = 64,
  parameter int init_val_p = 64,
  parameter int thresh_p   = 4,
  parameter int width_lp   = $clog2(max_val_p + 1)
) (
  input  logic                clk_i,
  input  logic                reset_n_i,
  input  logic                clear_i,
  input  logic                down_i,
  input  logic                up_i,
  input  logic                drain_req_i,
  output logic [width_lp-1:0] count_o,
  output logic                avail_o,
  output logic                full_o,
  output logic                low_o,
  output logic                drain_ack_o,
  output logic                error_o
);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  localparam logic [width_lp:0]   max_ext_lp    = (width_lp + 1)'(max_val_p);
  localparam logic [width_lp:0]   thresh_ext_lp = (width_lp + 1)'(thresh_p);
  localparam logic [width_lp-1:0] init_lp       = width_lp'(init_val_p);

  logic [width_lp-1:0] count_q, count_d;
  logic                error_q, error_d;
  logic                drain_ack_q, drain_ack_d;
  state_e              state_q, state_d;
  logic [width_lp:0]   count_ext_s, next_ext_s;

  assign count_ext_s = {1'b0, count_q};

  // Credit arithmetic, one bit wider than the count so saturation is detected instead of wrapping.
  always_comb begin
    next_ext_s = count_ext_s;
    error_d    = error_q;
    if (clear_i) begin
      next_ext_s = {1'b0, init_lp};
      error_d    = 1'b0;
    end else if (up_i && !down_i) begin
      if (count_ext_s >= max_ext_lp) begin
        error_d = 1'b1;
      end else begin
        next_ext_s = count_ext_s + {{width_lp{1'b0}}, 1'b1};
      end
    end else if (down_i && !up_i) begin
      if (count_ext_s == {(width_lp + 1){1'b0}}) begin
        error_d = 1'b1;
      end else begin
        next_ext_s = count_ext_s - {{width_lp{1'b0}}, 1'b1};
      end
    end else begin
      next_ext_s = count_ext_s;
    end
    count_d = next_ext_s[width_lp-1:0];
  end

  // Drain handshake; DRAIN/DONE judge fullness on the post-update count so ack lines up with count_o.
  always_comb begin
    state_d = state_q;
    if (clear_i) begin
      state_d = ST_RUN;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (drain_req_i) state_d = ST_DRAIN;
          else             state_d = ST_RUN;
        end
        ST_DRAIN: begin
          if (!drain_req_i)                  state_d = ST_RUN;
          else if (next_ext_s == max_ext_lp) state_d = ST_DONE;
          else                               state_d = ST_DRAIN;
        end
        ST_DONE: begin
          if (!drain_req_i)                 state_d = ST_RUN;
          else if (next_ext_s < max_ext_lp) state_d = ST_DRAIN;
          else                              state_d = ST_DONE;
        end
        default: state_d = ST_RUN;
      endcase
    end
    drain_ack_d = (state_d == ST_DONE);
  end

  // State and output registers.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      count_q     <= init_lp;
      error_q     <= 1'b0;
      drain_ack_q <= 1'b0;
      state_q     <= ST_RUN;
    end else begin
      count_q     <= count_d;
      error_q     <= error_d;
      drain_ack_q <= drain_ack_d;
      state_q     <= state_d;
    end
  end

  assign count_o     = count_q;
  assign error_o     = error_q;
  assign drain_ack_o = drain_ack_q;
  assign avail_o     = (count_q != {width_lp{1'b0}});
  assign full_o      = (count_ext_s == max_ext_lp);
  assign low_o       = (count_ext_s < thresh_ext_lp);

endmodule
